// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8N/8P data, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the sample point.
module uart_rx #(
  parameter int unsigned p_clk_speed_hz = 50_000_000,
  parameter int unsigned p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  input  logic       stop_sel_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CYCLES_PER_BIT = p_clk_speed_hz / p_baud_rate;
  localparam int unsigned HALF           = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned VOTE_LAT = 1;
`else
  localparam int unsigned VOTE_LAT = 0;
`endif
  // Decisions land VOTE_LAT cycles after the nominal sample point; only the start
  // decision moves, so every later bit stays centred on the same absolute time.
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF - 1 + VOTE_LAT);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(CYCLES_PER_BIT - 1);

  if (CYCLES_PER_BIT < 8) begin : g_cpb_check
    $error("uart_rx: CYCLES_PER_BIT must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             pen_q;
  logic             psel_q;
  logic             stop2_q;
  logic             perr_q;
  logic             ferr_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             perr_out_q;
  logic             ferr_out_q;
  logic             busy_q;
  logic             sample_d;
  logic             ferr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Two previous synchronised samples; with rx_s_q they form the voting window.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s_q};
  end

  always_comb begin
    sample_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
  end
`else
  always_comb begin
    sample_d = rx_s_q;
  end
`endif

  always_comb begin
    ferr_d = ferr_q | ~sample_d;
  end

  // Frame state machine; all outputs registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      psel_q     <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            pen_q     <= parity_en_i;
            psel_q    <= parity_sel_i;
            stop2_q   <= stop_sel_i;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == START_PT) begin
            cnt_q <= '0;
            if (sample_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_PT) begin
            cnt_q              <= '0;
            shift_q[bit_cnt_q] <= sample_d;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= pen_q ? S_PARITY : S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == BIT_PT) begin
            cnt_q   <= '0;
            perr_q  <= sample_d != (psel_q ? ^shift_q : ~^shift_q);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_PT) begin
            cnt_q  <= '0;
            ferr_q <= ferr_d;
            if (stop2_q && bit_cnt_q == 3'd0) begin
              bit_cnt_q <= 3'd1;
            end else begin
              // Leave mid-stop-bit so a following start edge is not missed.
              bit_cnt_q  <= '0;
              valid_q    <= 1'b1;
              data_q     <= shift_q;
              perr_out_q <= perr_q;
              ferr_out_q <= ferr_d;
              if (ferr_d) begin
                state_q <= S_BREAK;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial line driver pushes expected bytes/flags,
// a monitor pops and compares on every valid_o strobe.
module tb_uart_rx;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       parity_en_i;
  logic       parity_sel_i;
  logic       stop_sel_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  int   n_sent    = 0;

  uart_rx #(.p_clk_speed_hz(1_000_000), .p_baud_rate(100_000)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .parity_en_i  (parity_en_i),
    .parity_sel_i (parity_sel_i),
    .stop_sel_i   (stop_sel_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", data_o);
        end else begin
          e = exp_q.pop_front();
          check("strobe_data", 32'(data_o), 32'(e.d));
          check("strobe_parity_err", 32'(parity_err_o), 32'(e.perr));
          check("strobe_frame_err", 32'(frame_err_o), 32'(e.ferr));
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One bit time on the line; glitch_off inverts a single cycle inside the bit.
  task automatic drive_bit(input logic v, input int glitch_off);
    for (int c = 0; c < int'(CPB); c++) begin
      rx_i = (c == glitch_off) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Transmit one frame and push what the receiver should report for it.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic ps,
                            input logic st2, input logic pflip, input logic [1:0] stops,
                            input int gbit, input bit scramble);
    exp_t       e;
    logic [7:0] rxd;
    logic       pbit;
    parity_en_i  = pe;
    parity_sel_i = ps;
    stop_sel_i   = st2;
    pbit = (ps ? ^d : ~^d) ^ pflip;
    rxd  = d;
`ifndef UART_RX_MAJORITY_EN
    if (gbit >= 0) rxd[gbit] = ~d[gbit];
`endif
    e.d    = rxd;
    e.perr = pe && (pbit != (ps ? ^rxd : ~^rxd));
    e.ferr = ~stops[0] | (st2 & ~stops[1]);
    exp_q.push_back(e);
    n_sent++;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i], (i == gbit) ? 5 : -1);
      if (scramble && i == 2) begin
        parity_en_i  = 1'($urandom);
        parity_sel_i = 1'($urandom);
        stop_sel_i   = 1'($urandom);
      end
    end
    if (pe) drive_bit(pbit, -1);
    drive_bit(stops[0], -1);
    if (st2) drive_bit(stops[1], -1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpe, rps, rst2, rflip;
    logic [1:0] rstops;
    rst_i = 1'b1; rx_i = 1'b1;
    parity_en_i = 1'b0; parity_sel_i = 1'b0; stop_sel_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data_o), 32'h0);
    check("reset_valid", 32'(valid_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_errs", 32'({parity_err_o, frame_err_o}), 32'h0);
    rst_i = 1'b0;
    idle(5);

    // Plain frame, then line idle.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 1'b0);
    idle(8);
    check("idle_after_frame_busy", 32'(busy_o), 32'h0);

    // Parity good then forced bad.
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, -1, 1'b0);
    idle(5);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, -1, 1'b0);
    idle(5);

    // Break: bad stop bit, line held low, then a clean frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, -1, 1'b0);
    rx_i = 1'b0;
    repeat (50) @(negedge clk);
    check("break_busy_held", 32'(busy_o), 32'h1);
    idle(10);
    check("break_released_busy", 32'(busy_o), 32'h0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 1'b0);
    idle(5);

    // Short start glitch is rejected.
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    idle(12);
    check("start_glitch_busy", 32'(busy_o), 32'h0);

    // Single-cycle glitch at the centre of data bit 3.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3, 1'b0);
    idle(5);

    // Two stop bits, back to back, then with a bad second stop bit.
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1, 1'b0);
    idle(5);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, -1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, -1, 1'b0);
    idle(30);

    // Reset in the middle of data bit 4 (byte 0xC3 abandoned).
    rd = 8'hC3;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], -1);
    rx_i = rd[4];
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    rx_i  = 1'b1;
    check("midframe_reset_data", 32'(data_o), 32'h0);
    check("midframe_reset_busy", 32'(busy_o), 32'h0);
    check("midframe_reset_errs", 32'({parity_err_o, frame_err_o}), 32'h0);
    idle(30);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 1'b0);
    idle(5);

    // Random frames with mid-frame config scrambling and random gaps.
    for (int n = 0; n < 24; n++) begin
      rd     = 8'($urandom);
      rpe    = 1'($urandom);
      rps    = 1'($urandom);
      rst2   = 1'($urandom);
      rflip  = ($urandom_range(0, 3) == 0);
      rstops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
      send_frame(rd, rpe, rps, rst2, rflip, rstops, -1, 1'b1);
      if (!rstops[0] || (rst2 && !rstops[1])) idle(20 + int'($urandom_range(0, 10)));
      else idle(int'($urandom_range(0, 12)));
    end

    idle(40);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("strobe_count", 32'(n_strobes), 32'(n_sent));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
